// File: rtl/lock_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : lock_controller                                                  |
// | Desc   : 4-digit BCD keypad lock with retry lockout and timed auto-relock |
// | Rev    : 1.0 - initial release                                            |
// +---------------------------------------------------------------------------+
module lock_controller #(
  parameter logic [15:0] CODE           = 16'h1234,
  parameter int unsigned MAX_TRIES      = 3,
  parameter int unsigned UNLOCK_CYCLES  = 100_000_000,
  parameter int unsigned LOCKOUT_CYCLES = 200_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] digit,
  input  logic       digit_valid,
  input  logic       enter,
  input  logic       clear,
  input  logic       lock_req,
  output logic       state,
  output logic       alarm,
  output logic [2:0] digits_entered,
  output logic [2:0] fail_cnt
);

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    ENTRY    = 2'd1,
    UNLOCKED = 2'd2,
    LOCKOUT  = 2'd3
  } fsm_t;

  localparam logic [27:0] C_UNLOCK_LOAD  = 28'(UNLOCK_CYCLES - 1);
  localparam logic [27:0] C_LOCKOUT_LOAD = 28'(LOCKOUT_CYCLES - 1);
  localparam logic [2:0]  C_MAX_TRIES    = 3'(MAX_TRIES);

  fsm_t        fsm_q,    fsm_d;
  logic [15:0] buf_q,    buf_d;
  logic [2:0]  cnt_q,    cnt_d;
  logic [2:0]  fail_q,   fail_d;
  logic [27:0] timer_q,  timer_d;
  logic        unl_q,    unl_d;
  logic        alarm_q,  alarm_d;

  logic        w_key_ok;
  logic [2:0]  w_fail_inc;

  assign w_key_ok   = digit_valid && (digit <= 4'd9);
  assign w_fail_inc = fail_q + 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= LOCKED;
      buf_q   <= '0;
      cnt_q   <= '0;
      fail_q  <= '0;
      timer_q <= '0;
      unl_q   <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      fail_q  <= fail_d;
      timer_q <= timer_d;
      unl_q   <= unl_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    fsm_d   = fsm_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    fail_d  = fail_q;
    timer_d = timer_q;
    unl_d   = unl_q;
    alarm_d = alarm_q;
    case (fsm_q)
      LOCKED: begin
        // clear and enter outrank a coinciding keypress even here
        if (!clear && !enter && w_key_ok) begin
          buf_d = {12'h000, digit};
          cnt_d = 3'd1;
          fsm_d = ENTRY;
        end
      end
      ENTRY: begin
        if (clear) begin
          fsm_d = LOCKED;
          buf_d = '0;
          cnt_d = '0;
        end else if (enter) begin
          buf_d = '0;
          cnt_d = '0;
          if (cnt_q == 3'd4 && buf_q == CODE) begin
            fsm_d   = UNLOCKED;
            unl_d   = 1'b1;
            fail_d  = '0;
            timer_d = C_UNLOCK_LOAD;
          end else begin
            fail_d = w_fail_inc;
            if (w_fail_inc == C_MAX_TRIES) begin
              fsm_d   = LOCKOUT;
              alarm_d = 1'b1;
              timer_d = C_LOCKOUT_LOAD;
            end else begin
              fsm_d = LOCKED;
            end
          end
        end else if (w_key_ok && cnt_q < 3'd4) begin
          buf_d = {buf_q[11:0], digit};
          cnt_d = cnt_q + 3'd1;
        end
      end
      UNLOCKED: begin
        if (lock_req || timer_q == 28'd0) begin
          fsm_d = LOCKED;
          unl_d = 1'b0;
        end else begin
          timer_d = timer_q - 28'd1;
        end
      end
      LOCKOUT: begin
        if (timer_q == 28'd0) begin
          fsm_d   = LOCKED;
          alarm_d = 1'b0;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 28'd1;
        end
      end
      default: fsm_d = LOCKED;
    endcase
  end

  assign state          = unl_q;
  assign alarm          = alarm_q;
  assign digits_entered = cnt_q;
  assign fail_cnt       = fail_q;

endmodule
`default_nettype wire

// File: tb/tb_lock_controller.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | Module : tb_lock_controller                                               |
// | Desc   : Directed bench; expectations queued per cycle, checked by monitor|
// | Rev    : 1.0 - initial release                                            |
// +---------------------------------------------------------------------------+
module tb_lock_controller;

  localparam int unsigned U = 20;
  localparam int unsigned L = 30;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] digit = 4'd0;
  logic       digit_valid = 1'b0;
  logic       enter = 1'b0;
  logic       clear = 1'b0;
  logic       lock_req = 1'b0;
  logic       state;
  logic       alarm;
  logic [2:0] digits_entered;
  logic [2:0] fail_cnt;

  typedef struct {
    int         cyc;
    string      name;
    logic       st;
    logic       al;
    logic [2:0] de;
    logic [2:0] fc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  lock_controller #(
    .CODE(16'h1234),
    .MAX_TRIES(3),
    .UNLOCK_CYCLES(U),
    .LOCKOUT_CYCLES(L)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .digit(digit),
    .digit_valid(digit_valid),
    .enter(enter),
    .clear(clear),
    .lock_req(lock_req),
    .state(state),
    .alarm(alarm),
    .digits_entered(digits_entered),
    .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic exp_t mk(input string n, input logic st, input logic al,
                              input logic [2:0] de, input logic [2:0] fc, input int c);
    exp_t e;
    e.cyc = c; e.name = n; e.st = st; e.al = al; e.de = de; e.fc = fc;
    return e;
  endfunction

  function automatic void cmp(input exp_t e);
    n_vec++;
    if ({state, alarm, digits_entered, fail_cnt} !== {e.st, e.al, e.de, e.fc}) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got state=%0b alarm=%0b digits=%0d fail=%0d, want state=%0b alarm=%0b digits=%0d fail=%0d",
               e.name, cyc, state, alarm, digits_entered, fail_cnt, e.st, e.al, e.de, e.fc);
    end
  endfunction

  // Monitor: outputs settle on the rising edge, so compare on the falling edge
  initial forever begin
    @(negedge clk);
    while (sb.size() > 0 && sb[0].cyc <= cyc) cmp(sb.pop_front());
  end

  task automatic drive(input logic [3:0] d, input logic dv, input logic en, input logic clr,
                       input logic lr, input string n, input logic st, input logic al,
                       input logic [2:0] de, input logic [2:0] fc);
    digit = d; digit_valid = dv; enter = en; clear = clr; lock_req = lr;
    sb.push_back(mk(n, st, al, de, fc, cyc + 1));
    @(negedge clk);
    digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; lock_req = 1'b0;
  endtask

  task automatic key(input logic [3:0] d, input string n, input logic st, input logic al,
                     input logic [2:0] de, input logic [2:0] fc);
    drive(d, 1'b1, 1'b0, 1'b0, 1'b0, n, st, al, de, fc);
  endtask

  task automatic idle(input int k, input string n, input logic st, input logic al,
                      input logic [2:0] de, input logic [2:0] fc);
    repeat (k - 1) @(negedge clk);
    drive(4'd0, 1'b0, 1'b0, 1'b0, 1'b0, n, st, al, de, fc);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3 rst_n = 1'b0;
    #1 cmp(mk("reset", 1'b0, 1'b0, 3'd0, 3'd0, 0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Correct code with an out-of-range digit mixed in, then timed relock
    key(4'd1, "d1", 0, 0, 3'd1, 3'd0);
    key(4'd2, "d2", 0, 0, 3'd2, 3'd0);
    key(4'd3, "d3", 0, 0, 3'd3, 3'd0);
    key(4'hA, "digit_A_ignored", 0, 0, 3'd3, 3'd0);
    key(4'd4, "d4", 0, 0, 3'd4, 3'd0);
    drive(4'd0, 0, 1, 0, 0, "unlock", 1, 0, 3'd0, 3'd0);
    idle(U - 1, "unlock_hold", 1, 0, 3'd0, 3'd0);
    idle(1, "auto_relock", 0, 0, 3'd0, 3'd0);

    // Short entry fails; overlong entry saturates at 1234 and unlocks
    key(4'd1, "s1", 0, 0, 3'd1, 3'd0);
    key(4'd2, "s2", 0, 0, 3'd2, 3'd0);
    drive(4'd0, 0, 1, 0, 0, "short_fail", 0, 0, 3'd0, 3'd1);
    for (int i = 1; i <= 6; i++)
      key(4'(i), "long_digit", 0, 0, (i < 4) ? 3'(i) : 3'd4, 3'd1);
    drive(4'd0, 0, 1, 0, 0, "overflow_unlock", 1, 0, 3'd0, 3'd0);
    idle(9, "unl_wait", 1, 0, 3'd0, 3'd0);
    key(4'd1, "unl_digit_ignored", 1, 0, 3'd0, 3'd0);
    drive(4'd0, 0, 0, 0, 1, "lock_req", 0, 0, 3'd0, 3'd0);

    // Three wrong codes -> lockout, strobes ignored, timed exit
    for (int t = 1; t <= 3; t++) begin
      key(4'd1, "w1", 0, 0, 3'd1, 3'(t - 1));
      key(4'd2, "w2", 0, 0, 3'd2, 3'(t - 1));
      key(4'd3, "w3", 0, 0, 3'd3, 3'(t - 1));
      key(4'd5, "w5", 0, 0, 3'd4, 3'(t - 1));
      drive(4'd0, 0, 1, 0, 0, "wrong_enter", 0, (t == 3), 3'd0, 3'(t));
    end
    key(4'd1, "lo_digit_ignored", 0, 1, 3'd0, 3'd3);
    drive(4'd0, 0, 0, 1, 0, "lo_clear_ignored", 0, 1, 3'd0, 3'd3);
    drive(4'd0, 0, 1, 0, 0, "lo_enter_ignored", 0, 1, 3'd0, 3'd3);
    idle(L - 4, "lo_hold", 0, 1, 3'd0, 3'd3);
    idle(1, "lo_exit", 0, 0, 3'd0, 3'd0);

    // Clear beats enter; fail count preserved; invalid digit in LOCKED ignored
    key(4'd1, "c1", 0, 0, 3'd1, 3'd0);
    key(4'd2, "c2", 0, 0, 3'd2, 3'd0);
    key(4'd3, "c3", 0, 0, 3'd3, 3'd0);
    key(4'd5, "c5", 0, 0, 3'd4, 3'd0);
    drive(4'd0, 0, 1, 0, 0, "fail1", 0, 0, 3'd0, 3'd1);
    key(4'd7, "c7", 0, 0, 3'd1, 3'd1);
    drive(4'd0, 0, 1, 1, 0, "clear_enter", 0, 0, 3'd0, 3'd1);
    drive(4'd0, 0, 1, 0, 0, "locked_enter_ignored", 0, 0, 3'd0, 3'd1);
    key(4'hA, "locked_A_ignored", 0, 0, 3'd0, 3'd1);
    key(4'd9, "locked_d9", 0, 0, 3'd1, 3'd1);
    drive(4'd0, 0, 1, 0, 0, "fail2", 0, 0, 3'd0, 3'd2);
    key(4'd5, "k5", 0, 0, 3'd1, 3'd2);
    drive(4'd0, 0, 1, 0, 0, "lockout2", 0, 1, 3'd0, 3'd3);
    idle(3, "lo2_hold", 0, 1, 3'd0, 3'd3);

    // Asynchronous reset mid-lockout, then normal operation resumes
    rst_n = 1'b0;
    #1 cmp(mk("async_reset", 1'b0, 1'b0, 3'd0, 3'd0, 0));
    @(negedge clk);
    rst_n = 1'b1;
    key(4'd1, "r1", 0, 0, 3'd1, 3'd0);
    key(4'd2, "r2", 0, 0, 3'd2, 3'd0);
    key(4'd3, "r3", 0, 0, 3'd3, 3'd0);
    key(4'd4, "r4", 0, 0, 3'd4, 3'd0);
    drive(4'd0, 0, 1, 0, 0, "post_reset_unlock", 1, 0, 3'd0, 3'd0);

    repeat (3) @(negedge clk);
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/lock_controller.md
LOCK_CONTROLLER -- requirements
Module: lock_controller

Interface
REQ-001 The block SHALL take parameter CODE, default 16'h1234, meaning the four BCD digits of the secret code, most-significant digit entered first.
REQ-002 The block SHALL take parameter MAX_TRIES, default 3, meaning the number of consecutive failed attempts that triggers lockout (legal range 1-7).
REQ-003 The block SHALL take parameter UNLOCK_CYCLES, default 100_000_000, meaning the clock cycles spent in UNLOCKED before automatic relock.
REQ-004 The block SHALL take parameter LOCKOUT_CYCLES, default 200_000_000, meaning the clock cycles spent in LOCKOUT.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 The block SHALL have port digit, input, 4 bits: the keypad digit, qualified by digit_valid.
REQ-008 The block SHALL have port digit_valid, input, 1 bit: a one-cycle strobe marking a new keypress.
REQ-009 The block SHALL have port enter, input, 1 bit: a one-cycle strobe that submits the entered code.
REQ-010 The block SHALL have port clear, input, 1 bit: a one-cycle strobe that discards the current entry.
REQ-011 The block SHALL have port lock_req, input, 1 bit: a one-cycle strobe that forces an immediate relock from UNLOCKED.
REQ-012 The block SHALL have port state, output, 1 bit: 1 = unlocked, 0 = locked; it feeds the downstream letter display (U/L).
REQ-013 The block SHALL have port alarm, output, 1 bit: 1 while in LOCKOUT.
REQ-014 The block SHALL have port digits_entered, output, 3 bits: the count of digits accepted in the current entry (0-4).
REQ-015 The block SHALL have port fail_cnt, output, 3 bits: the count of consecutive failed attempts.

Function
REQ-016 The FSM SHALL have exactly four states: LOCKED, ENTRY, UNLOCKED, LOCKOUT; all outputs SHALL be registered and reflect the state entered on the same clock edge (1-cycle latency from strobe to output).
REQ-017 A digit_valid with digit > 9 SHALL be ignored in every state.
REQ-018 In LOCKED, a valid digit SHALL be loaded into the low nibble of a 16-bit entry buffer, set digits_entered to 1, and move the FSM to ENTRY; enter and lock_req SHALL be ignored in LOCKED.
REQ-019 In ENTRY, each valid digit SHALL shift the buffer left by 4 bits, insert the new digit in the low nibble, and increment digits_entered while it is below 4; digits arriving when digits_entered = 4 SHALL be ignored.
REQ-020 In ENTRY, enter with digits_entered = 4 and buffer = CODE SHALL move the FSM to UNLOCKED, set state = 1, clear fail_cnt, and load the relock timer with UNLOCK_CYCLES-1.
REQ-021 In ENTRY, any other enter SHALL count as a failure: fail_cnt increments; if the new value equals MAX_TRIES, the FSM SHALL move to LOCKOUT, set alarm = 1, and load the lockout timer with LOCKOUT_CYCLES-1; otherwise the FSM SHALL return to LOCKED.
REQ-022 In ENTRY, clear SHALL return the FSM to LOCKED with no change to fail_cnt.
REQ-023 On every exit from ENTRY, the buffer and digits_entered SHALL be cleared to 0.
REQ-024 When strobes coincide in the same cycle, priority SHALL be clear > enter > digit_valid; only the highest-priority strobe takes effect.
REQ-025 In UNLOCKED, the timer SHALL decrement once per cycle; when it reaches 0, or when lock_req is high, the FSM SHALL move to LOCKED on the next edge with state = 0; digits, enter, and clear SHALL be ignored.
REQ-026 In LOCKOUT, every input strobe SHALL be ignored; the timer SHALL decrement, and when it reaches 0 the FSM SHALL move to LOCKED with alarm = 0 and fail_cnt = 0.
REQ-027 A single shared down-counter of 28 bits SHALL serve as both the relock timer and the lockout timer; it SHALL hold its value in LOCKED and in ENTRY.

Reset
REQ-028 While rst_n = 0, the block SHALL immediately enter LOCKED with state = 0, alarm = 0, digits_entered = 0, fail_cnt = 0, buffer = 0, and timer = 0, regardless of clk.
REQ-029 Reset asserted during ENTRY, UNLOCKED, or LOCKOUT SHALL abort that operation with no residual effect; the first edge after rst_n rises SHALL be treated as LOCKED.

Verification
REQ-030 Bench: enter digits 1,2,3,4 then enter -> state = 1 on the edge after enter, fail_cnt = 0, and state = 0 exactly UNLOCK_CYCLES cycles later.
REQ-031 Bench: enter 1,2,3,5 then enter, three times with MAX_TRIES = 3 -> fail_cnt steps 1,2,3; alarm = 1 after the third enter; digits are ignored during lockout; after LOCKOUT_CYCLES, alarm = 0 and fail_cnt = 0.
REQ-032 Bench: enter 1,2 then enter -> failure, with fail_cnt = 1 and digits_entered = 0; enter 1,2,3,4,5,6 then enter -> buffer = 1234, unlock.
REQ-033 Bench: clear and enter in the same cycle during ENTRY -> LOCKED with fail_cnt unchanged; digit_valid with digit = 4'hA -> digits_entered unchanged.
REQ-034 Bench: unlock, then lock_req after 10 cycles -> state = 0 on the next edge.
REQ-035 Bench: assert rst_n = 0 mid-LOCKOUT -> alarm = 0 and fail_cnt = 0 immediately, without a clock edge.
